ocp_arbiter2: RTL and testbench

//  Two-master to one-slave OCP arbiter sharing the single behavioral memory port between

---
 rtl/ocp_arbiter2.sv | 138 +++++++++++++
 tb/tb_ocp_arbiter2.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_arbiter2.sv
`timescale 1ns/1ps
// ocp_arbiter2: shares one OCP slave port between two masters (M0 = instruction
// fetch, M1 = data). Round-robin grant with one transaction in flight. The
// command is muxed to the slave, and the response goes back to the granted master only.
module ocp_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0] i_M0_MAddr,
  input  logic [2:0]            i_M0_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M0_MData,
  input  logic [BEN_WIDTH-1:0]  i_M0_MByteEn,
  output logic                  o_M0_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M0_SData,
  output logic [1:0]            o_M0_SResp,
  // master 1 (data access)
  input  logic [ADDR_WIDTH-1:0] i_M1_MAddr,
  input  logic [2:0]            i_M1_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M1_MData,
  input  logic [BEN_WIDTH-1:0]  i_M1_MByteEn,
  output logic                  o_M1_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M1_SData,
  output logic [1:0]            o_M1_SResp,
  // slave port
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q;
  logic   grant_q;  // 0 = M0, 1 = M1
  logic   last_q;   // master that completed the most recent transaction

  logic       m0_req;
  logic       m1_req;
  logic       arb_pick;
  logic [2:0] g_cmd;

  assign m0_req   = (i_M0_MCmd != OCP_CMD_IDLE);
  assign m1_req   = (i_M1_MCmd != OCP_CMD_IDLE);
  // On a tie the master that was not served last wins; otherwise the sole requester.
  assign arb_pick = (m0_req && m1_req) ? ~last_q : m1_req;
  assign g_cmd    = grant_q ? i_M1_MCmd : i_M0_MCmd;

  // Transaction FSM: arbitrate in IDLE, hold grant through command and response phases.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            grant_q <= arb_pick;
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (g_cmd == OCP_CMD_IDLE) begin
            // master withdrew its command before accept: abandon without crediting it
            state_q <= ST_IDLE;
          end else if (i_SCmdAccept) begin
            if (g_cmd == OCP_CMD_READ) begin
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
              last_q  <= grant_q;
            end
          end
        end
        ST_RESP: begin
          if (i_SResp != OCP_RESP_NULL) begin
            state_q <= ST_IDLE;
            last_q  <= grant_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Command/response routing: slave sees only the granted master, only the granted master sees the slave.
  always_comb begin
    o_MAddr         = '0;
    o_MCmd          = OCP_CMD_IDLE;
    o_MData         = '0;
    o_MByteEn       = '0;
    o_M0_SCmdAccept = 1'b0;
    o_M1_SCmdAccept = 1'b0;
    o_M0_SData      = '0;
    o_M0_SResp      = OCP_RESP_NULL;
    o_M1_SData      = '0;
    o_M1_SResp      = OCP_RESP_NULL;
    if (state_q == ST_CMD) begin
      if (grant_q) begin
        o_MAddr         = i_M1_MAddr;
        o_MCmd          = i_M1_MCmd;
        o_MData         = i_M1_MData;
        o_MByteEn       = i_M1_MByteEn;
        o_M1_SCmdAccept = i_SCmdAccept;
      end else begin
        o_MAddr         = i_M0_MAddr;
        o_MCmd          = i_M0_MCmd;
        o_MData         = i_M0_MData;
        o_MByteEn       = i_M0_MByteEn;
        o_M0_SCmdAccept = i_SCmdAccept;
      end
    end else if (state_q == ST_RESP) begin
      if (grant_q) begin
        o_M1_SData = i_SData;
        o_M1_SResp = i_SResp;
      end else begin
        o_M0_SData = i_SData;
        o_M0_SResp = i_SResp;
      end
    end
  end

endmodule

// File: tb/tb_ocp_arbiter2.sv
`timescale 1ns/1ps
// tb_ocp_arbiter2: directed stimulus through two master drivers and a small
// memory slave; grant order and read responses are checked against queues
// filled when each request is issued.
module tb_ocp_arbiter2;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_WR   = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;

  typedef struct packed {
    logic        m;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic [2:0]  mcmd  [2];
  logic [31:0] maddr [2];
  logic [31:0] mdata [2];
  logic [3:0]  mbe   [2];

  logic        m0_acc, m1_acc;
  logic [31:0] m0_sdata, m1_sdata;
  logic [1:0]  m0_sresp, m1_sresp;
  logic [31:0] s_maddr, s_mdata;
  logic [2:0]  s_mcmd;
  logic [3:0]  s_mbe;
  logic        s_accept;
  logic [31:0] s_sdata;
  logic [1:0]  s_sresp;

  // slave model state
  logic [31:0] mem [16];
  logic [1:0]  mdl_resp;
  logic [31:0] mdl_data;
  logic        ovr_en;
  logic        noresp;

  assign s_accept = (s_mcmd != C_IDLE);
  assign s_sresp  = ovr_en ? R_DVA : mdl_resp;
  assign s_sdata  = ovr_en ? 32'h5a5a5a5a : mdl_data;

  ocp_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .i_M0_MAddr      (maddr[0]),
    .i_M0_MCmd       (mcmd[0]),
    .i_M0_MData      (mdata[0]),
    .i_M0_MByteEn    (mbe[0]),
    .o_M0_SCmdAccept (m0_acc),
    .o_M0_SData      (m0_sdata),
    .o_M0_SResp      (m0_sresp),
    .i_M1_MAddr      (maddr[1]),
    .i_M1_MCmd       (mcmd[1]),
    .i_M1_MData      (mdata[1]),
    .i_M1_MByteEn    (mbe[1]),
    .o_M1_SCmdAccept (m1_acc),
    .o_M1_SData      (m1_sdata),
    .o_M1_SResp      (m1_sresp),
    .o_MAddr         (s_maddr),
    .o_MCmd          (s_mcmd),
    .o_MData         (s_mdata),
    .o_MByteEn       (s_mbe),
    .i_SCmdAccept    (s_accept),
    .i_SData         (s_sdata),
    .i_SResp         (s_sresp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        rq0 [$];
  txn_t        rq1 [$];
  txn_t        oq  [$];
  logic [31:0] eq0 [$];
  logic [31:0] eq1 [$];
  bit          busy [2];
  int          cyc  [2];
  int          lat  [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // queue a master request; reads also queue the expected read data
  task automatic issue(input logic m, input logic [2:0] cmd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp_rd);
    txn_t t;
    t.m = m; t.cmd = cmd; t.addr = a; t.data = d; t.be = be;
    if (m) rq1.push_back(t); else rq0.push_back(t);
    if (cmd == C_RD) begin
      if (m) eq1.push_back(exp_rd); else eq0.push_back(exp_rd);
    end
    $display("issue   M%0d cmd=%0d addr=%h data=%h be=%h", m, cmd, a, d, be);
  endtask

  // expected order in which the slave accepts commands
  task automatic exp_grant(input logic m, input logic [2:0] cmd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    txn_t t;
    t.m = m; t.cmd = cmd; t.addr = a; t.data = d; t.be = be;
    oq.push_back(t);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mcmd"},  {61'd0, s_mcmd}, {61'd0, C_IDLE});
    chk({tag, "_maddr"}, {32'd0, s_maddr}, 64'd0);
    chk({tag, "_mdata"}, {32'd0, s_mdata}, 64'd0);
    chk({tag, "_mbe"},   {60'd0, s_mbe}, 64'd0);
    chk({tag, "_acc"},   {62'd0, m0_acc, m1_acc}, 64'd0);
    chk({tag, "_m0resp"}, {62'd0, m0_sresp}, {62'd0, R_NULL});
    chk({tag, "_m1resp"}, {62'd0, m1_sresp}, {62'd0, R_NULL});
    chk({tag, "_sdata"}, {m0_sdata, m1_sdata}, 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rq0.size() == 0 && rq1.size() == 0 && oq.size() == 0 && eq0.size() == 0 &&
          eq1.size() == 0 && !busy[0] && !busy[1]) begin
        done = 1;
        break;
      end
    end
    if (!done) chk({tag, "_drain_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // slave: always accepts, read data returned the cycle after accept
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mdl_resp = R_NULL;
    mdl_data = '0;
    forever begin
      @(posedge clk);
      mdl_resp <= R_NULL;
      mdl_data <= '0;
      if (s_accept && s_mcmd == C_WR) begin
        for (int b = 0; b < 4; b++)
          if (s_mbe[b]) mem[s_maddr[5:2]][8*b +: 8] <= s_mdata[8*b +: 8];
      end
      if (s_accept && s_mcmd == C_RD && !noresp) begin
        mdl_resp <= R_DVA;
        mdl_data <= mem[s_maddr[5:2]];
      end
    end
  end

  // master drivers: hold each command until it is accepted, then load the next
  initial begin
    bit   acc [2];
    txn_t t;
    for (int m = 0; m < 2; m++) begin
      mcmd[m] = C_IDLE; maddr[m] = '0; mdata[m] = '0; mbe[m] = '0;
      busy[m] = 0; cyc[m] = 0; lat[m] = 0;
    end
    forever begin
      @(negedge clk);
      acc[0] = m0_acc;
      acc[1] = m1_acc;
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (busy[m]) begin
          cyc[m]++;
          if (acc[m]) begin
            busy[m] = 0; lat[m] = cyc[m];
            mcmd[m] = C_IDLE; maddr[m] = '0; mdata[m] = '0; mbe[m] = '0;
          end else if (cyc[m] > 100) begin
            chk("accept_timeout", 64'(m), 64'hffff);
            busy[m] = 0;
            mcmd[m] = C_IDLE; maddr[m] = '0; mdata[m] = '0; mbe[m] = '0;
          end
        end
        if (!busy[m] && ((m == 0 && rq0.size() > 0) || (m == 1 && rq1.size() > 0))) begin
          t = (m == 0) ? rq0.pop_front() : rq1.pop_front();
          mcmd[m] = t.cmd; maddr[m] = t.addr; mdata[m] = t.data; mbe[m] = t.be;
          busy[m] = 1; cyc[m] = 0;
        end
      end
    end
  end

  // monitor: grant order on the slave side, responses on each master side
  initial begin
    txn_t        e;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (s_accept) begin
          if (oq.size() == 0) begin
            chk("unexpected_accept", {61'd0, s_mcmd}, {61'd0, C_IDLE});
          end else begin
            e = oq.pop_front();
            $display("accept  M%0d cmd=%0d addr=%h data=%h be=%h", m1_acc, s_mcmd, s_maddr, s_mdata, s_mbe);
            chk("grant_master", {62'd0, m0_acc, m1_acc}, e.m ? 64'd1 : 64'd2);
            chk("grant_cmd",  {61'd0, s_mcmd}, {61'd0, e.cmd});
            chk("grant_addr", {32'd0, s_maddr}, {32'd0, e.addr});
            chk("grant_data", {32'd0, s_mdata}, {32'd0, e.data});
            chk("grant_be",   {60'd0, s_mbe}, {60'd0, e.be});
          end
        end
        if (m0_sresp != R_NULL) begin
          if (eq0.size() == 0) begin
            chk("m0_unexpected_resp", {62'd0, m0_sresp}, {62'd0, R_NULL});
          end else begin
            x = eq0.pop_front();
            $display("resp    M0 data=%h resp=%0d", m0_sdata, m0_sresp);
            chk("m0_rdata", {32'd0, m0_sdata}, {32'd0, x});
            chk("m0_sresp", {62'd0, m0_sresp}, {62'd0, R_DVA});
            chk("m1_isolated_during_m0", {30'd0, m1_sresp, m1_sdata}, 64'd0);
          end
        end
        if (m1_sresp != R_NULL) begin
          if (eq1.size() == 0) begin
            chk("m1_unexpected_resp", {62'd0, m1_sresp}, {62'd0, R_NULL});
          end else begin
            x = eq1.pop_front();
            $display("resp    M1 data=%h resp=%0d", m1_sdata, m1_sresp);
            chk("m1_rdata", {32'd0, m1_sdata}, {32'd0, x});
            chk("m1_sresp", {62'd0, m1_sresp}, {62'd0, R_DVA});
            chk("m0_isolated_during_m1", {30'd0, m0_sresp, m0_sdata}, 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // directed stimulus
  initial begin
    bit seen;
    nrst = 1'b0; ovr_en = 1'b0; noresp = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    nrst = 1'b1;
    @(negedge clk);

    // 1: lone M0 write
    issue(1'b0, C_WR, 32'h0, 32'hdeadbeef, 4'hf, 32'h0);
    exp_grant(1'b0, C_WR, 32'h0, 32'hdeadbeef, 4'hf);
    wait_idle("t1");
    chk("t1_arb_latency", 64'(lat[0]), 64'd2);
    chk("t1_mem0", {32'd0, mem[0]}, 64'h00000000deadbeef);

    // 2: M0 read back
    issue(1'b0, C_RD, 32'h0, 32'h0, 4'hf, 32'hdeadbeef);
    exp_grant(1'b0, C_RD, 32'h0, 32'h0, 4'hf);
    wait_idle("t2");

    // 3: ties after reset, after an M1 read, after an M1 write
    issue(1'b1, C_WR, 32'h4, 32'h12345678, 4'hf, 32'h0);
    exp_grant(1'b1, C_WR, 32'h4, 32'h12345678, 4'hf);
    wait_idle("t3a");
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      issue(1'b0, C_RD, 32'h0, 32'h0, 4'hf, 32'hdeadbeef);
      issue(1'b1, C_RD, 32'h4, 32'h0, 4'hf, 32'h12345678);
      exp_grant(1'b0, C_RD, 32'h0, 32'h0, 4'hf);
      exp_grant(1'b1, C_RD, 32'h4, 32'h0, 4'hf);
      wait_idle("t3_tie");
    end
    issue(1'b1, C_WR, 32'h8, 32'hcafef00d, 4'hf, 32'h0);
    exp_grant(1'b1, C_WR, 32'h8, 32'hcafef00d, 4'hf);
    wait_idle("t3b");
    issue(1'b0, C_RD, 32'h8, 32'h0, 4'hf, 32'hcafef00d);
    issue(1'b1, C_RD, 32'h4, 32'h0, 4'hf, 32'h12345678);
    exp_grant(1'b0, C_RD, 32'h8, 32'h0, 4'hf);
    exp_grant(1'b1, C_RD, 32'h4, 32'h0, 4'hf);
    wait_idle("t3c");

    // 4: M1 partial write (low two bytes), M0 reads merged word
    issue(1'b1, C_WR, 32'h0, 32'hbeefdead, 4'h3, 32'h0);
    exp_grant(1'b1, C_WR, 32'h0, 32'hbeefdead, 4'h3);
    wait_idle("t4a");
    issue(1'b0, C_RD, 32'h0, 32'h0, 4'hf, 32'hdeaddead);
    exp_grant(1'b0, C_RD, 32'h0, 32'h0, 4'hf);
    wait_idle("t4b");

    // 5: reset while waiting for a read response; late response must be dropped
    noresp = 1'b1;
    issue(1'b0, C_RD, 32'h0, 32'h0, 4'hf, 32'h0);
    eq0.delete();
    exp_grant(1'b0, C_RD, 32'h0, 32'h0, 4'hf);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (oq.size() == 0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("t5_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    nrst = 1'b0;
    ovr_en = 1'b1;
    #1;
    check_reset("t5_rst");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    noresp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_late_resp_m0", {62'd0, m0_sresp}, {62'd0, R_NULL});
      chk("t5_late_data_m0", {32'd0, m0_sdata}, 64'd0);
    end
    ovr_en = 1'b0;
    @(negedge clk);
    issue(1'b1, C_RD, 32'h8, 32'h0, 4'hf, 32'hcafef00d);
    issue(1'b0, C_RD, 32'h0, 32'h0, 4'hf, 32'hdeaddead);
    exp_grant(1'b0, C_RD, 32'h0, 32'h0, 4'hf);
    exp_grant(1'b1, C_RD, 32'h8, 32'h0, 4'hf);
    wait_idle("t5");

    // 6: M1 streaming reads, M0 slips in after the read in progress
    for (int i = 0; i < 4; i++) issue(1'b1, C_RD, 32'h4, 32'h0, 4'hf, 32'h12345678);
    exp_grant(1'b1, C_RD, 32'h4, 32'h0, 4'hf);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m1_acc) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("t6_m1_start_timeout", 64'd0, 64'd1);
    issue(1'b0, C_RD, 32'h8, 32'h0, 4'hf, 32'hcafef00d);
    exp_grant(1'b0, C_RD, 32'h8, 32'h0, 4'hf);
    for (int i = 0; i < 3; i++) exp_grant(1'b1, C_RD, 32'h4, 32'h0, 4'hf);
    wait_idle("t6");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
